// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with start-bit qualification, mid-bit sampling and stop-bit check.
// Optional build macro UART_RX_MAJORITY_EN: each sample is a 2-of-3 vote over the last three synchronized values.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx_i,
  output logic [7:0] d_o,
  output logic       valid_o,
  output logic       frame_err_o,
  output logic       busy_o
);
  localparam int H  = CLKS_PER_BIT / 2;
  localparam int C  = CLKS_PER_BIT;
  localparam int TW = $clog2(C) + 1;
  localparam logic [TW-1:0] HALF_LOAD = TW'(H - 1);
  localparam logic [TW-1:0] BIT_LOAD  = TW'(C - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          sync1_q, sync2_q, edge_q;
  logic          fall;
  logic          sample_pt;
  logic          sample_bit;

  // The edge register resets low so a frame needs the line seen high first.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
    end
  end

  assign fall      = edge_q & ~sync2_q;
  assign sample_pt = (timer_q == '0);

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], sync2_q};
    end
  end

  assign sample_bit = (sync2_q & hist_q[0]) | (sync2_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
  assign sample_bit = sync2_q;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = (timer_q != '0) ? timer_q - TW'(1) : timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (fall) begin
          timer_d = HALF_LOAD;
          state_d = START;
        end
      end
      START: begin
        if (sample_pt) begin
          if (!sample_bit) begin
            timer_d   = BIT_LOAD;
            bit_idx_d = 3'd0;
            state_d   = DATA;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (sample_pt) begin
          shift_d[bit_idx_q] = sample_bit;
          timer_d            = BIT_LOAD;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (sample_pt) begin
          if (sample_bit) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        // Break or misaligned frame: wait for the line to return high.
        if (sync2_q) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  assign d_o         = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at CLKS_PER_BIT=16 with a frame-level reference model.
// Honours UART_RX_MAJORITY_EN for the mid-bit glitch expectation.
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int C = 16;
  localparam int H = C / 2;
  localparam int FRAME_LAT = 3 + H + 9 * C;

  logic       clk;
  logic       resetn;
  logic       rx_i;
  logic [7:0] d_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       busy_o;

  int vectors;
  int miscompares;
  int cyc;
  int last_fall;
  int overlap;
  logic prev_busy;

  logic [7:0] got_q[$];
  int         got_cyc[$];
  logic       got_busy[$];
  logic       got_pbusy[$];
  int         ferr_cyc[$];

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .rx_i        (rx_i),
    .d_o         (d_o),
    .valid_o     (valid_o),
    .frame_err_o (frame_err_o),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Records every output pulse with the negedge cycle count at which it was seen.
  initial begin
    overlap   = 0;
    prev_busy = 1'b0;
  end
  always @(negedge clk) begin
    if (resetn) begin
      if (valid_o) begin
        got_q.push_back(d_o);
        got_cyc.push_back(cyc);
        got_busy.push_back(busy_o);
        got_pbusy.push_back(prev_busy);
        $display("rx byte 0x%02h at cycle %0d", d_o, cyc);
      end
      if (frame_err_o) begin
        ferr_cyc.push_back(cyc);
        $display("rx frame error at cycle %0d", cyc);
      end
      if (valid_o && frame_err_o) overlap++;
    end
    prev_busy = busy_o;
  end

  task automatic clear_log();
    got_q.delete();
    got_cyc.delete();
    got_busy.delete();
    got_pbusy.delete();
    ferr_cyc.delete();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_i = 1'b1;
    end
  endtask

  // Drives one serial frame; gmask[k] inverts the line for one cycle at mid-bit k.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int stop_len,
                            input logic [9:0] gmask);
    logic bitv;
    int   len;
    for (int k = 0; k < 10; k++) begin
      if (k == 0)      bitv = 1'b0;
      else if (k == 9) bitv = stop;
      else             bitv = b[k-1];
      len = (k == 9) ? stop_len : C;
      for (int i = 0; i < len; i++) begin
        @(negedge clk);
        if (k == 0 && i == 0) last_fall = cyc;
        rx_i = (gmask[k] && i == H) ? ~bitv : bitv;
      end
    end
  endtask

  task automatic test_reset();
    rx_i   = 1'b1;
    resetn = 1'b0;
    repeat (4) @(negedge clk);
    vectors += 4;
    if (d_o !== 8'h00) begin miscompares++; $display("FAIL reset_d_o: got %02h want 00", d_o); end
    if (valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    if (frame_err_o !== 1'b0) begin miscompares++; $display("FAIL reset_ferr: got %b want 0", frame_err_o); end
    if (busy_o !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    resetn = 1'b1;
    idle(4);
  endtask

  task automatic test_single();
    clear_log();
    send_frame(8'hA5, 1'b1, C, 10'd0);
    idle(C);
    vectors += 2;
    if (got_q.size() != 1) begin miscompares++; $display("FAIL single_count: got %0d want 1", got_q.size()); end
    if (ferr_cyc.size() != 0) begin miscompares++; $display("FAIL single_ferr: got %0d want 0", ferr_cyc.size()); end
    if (got_q.size() >= 1) begin
      vectors += 4;
      if (got_q[0] !== 8'hA5) begin miscompares++; $display("FAIL single_data: got %02h want a5", got_q[0]); end
      if (got_cyc[0] - last_fall != FRAME_LAT) begin
        miscompares++; $display("FAIL single_latency: got %0d want %0d", got_cyc[0] - last_fall, FRAME_LAT);
      end
      if (got_busy[0] !== 1'b0) begin miscompares++; $display("FAIL single_busy_fall: got %b want 0", got_busy[0]); end
      if (got_pbusy[0] !== 1'b1) begin miscompares++; $display("FAIL single_busy_before: got %b want 1", got_pbusy[0]); end
    end
    vectors++;
    if (d_o !== 8'hA5) begin miscompares++; $display("FAIL single_hold: got %02h want a5", d_o); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    clear_log();
    exp_q = '{8'h00, 8'hFF, 8'h3C};
    for (int i = 0; i < 5; i++) exp_q.push_back(8'($urandom_range(0, 255)));
    foreach (exp_q[i]) send_frame(exp_q[i], 1'b1, C, 10'd0);
    idle(2 * C);
    vectors += 2;
    if (got_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL b2b_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    if (ferr_cyc.size() != 0) begin miscompares++; $display("FAIL b2b_ferr: got %0d want 0", ferr_cyc.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL b2b_data[%0d]: got %02h want %02h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_glitch();
    int busy_cnt;
    clear_log();
    busy_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy_o) busy_cnt++;
      rx_i = (i < 3) ? 1'b0 : 1'b1;
    end
    vectors += 3;
    if (busy_cnt != 8) begin miscompares++; $display("FAIL glitch_busy: got %0d want 8", busy_cnt); end
    if (got_q.size() != 0) begin miscompares++; $display("FAIL glitch_valid: got %0d want 0", got_q.size()); end
    if (ferr_cyc.size() != 0) begin miscompares++; $display("FAIL glitch_ferr: got %0d want 0", ferr_cyc.size()); end
  endtask

  task automatic test_frame_err();
    logic [7:0] first_b;
    logic [7:0] next_b;
    int         rise_cyc;
    int         fall_seen;
    first_b = 8'($urandom_range(1, 255));
    next_b  = 8'($urandom_range(0, 255));
    send_frame(first_b, 1'b1, C, 10'd0);
    idle(C);
    clear_log();
    send_frame(8'h55, 1'b0, C + 40, 10'd0);
    @(negedge clk);
    rise_cyc  = cyc;
    rx_i      = 1'b1;
    fall_seen = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fall_seen < 0 && !busy_o) fall_seen = cyc;
    end
    vectors += 5;
    if (ferr_cyc.size() != 1) begin miscompares++; $display("FAIL ferr_count: got %0d want 1", ferr_cyc.size()); end
    else if (ferr_cyc[0] - last_fall != FRAME_LAT) begin
      miscompares++; $display("FAIL ferr_latency: got %0d want %0d", ferr_cyc[0] - last_fall, FRAME_LAT);
    end
    if (got_q.size() != 0) begin miscompares++; $display("FAIL ferr_valid: got %0d want 0", got_q.size()); end
    if (d_o !== first_b) begin miscompares++; $display("FAIL ferr_hold: got %02h want %02h", d_o, first_b); end
    if (fall_seen - rise_cyc != 3) begin
      miscompares++; $display("FAIL ferr_busy_fall: got %0d want 3", fall_seen - rise_cyc);
    end
    if (overlap != 0) begin miscompares++; $display("FAIL pulse_overlap: got %0d want 0", overlap); end
    clear_log();
    send_frame(next_b, 1'b1, C, 10'd0);
    idle(C);
    vectors += 2;
    if (got_q.size() != 1) begin miscompares++; $display("FAIL ferr_next_count: got %0d want 1", got_q.size()); end
    if (d_o !== next_b) begin miscompares++; $display("FAIL ferr_next_data: got %02h want %02h", d_o, next_b); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    b = 8'h81;
    clear_log();
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < ((k == 4) ? H : C); i++) begin
        @(negedge clk);
        rx_i = (k == 0) ? 1'b0 : b[k-1];
      end
    end
    vectors++;
    if (busy_o !== 1'b1) begin miscompares++; $display("FAIL rst_mid_busy_pre: got %b want 1", busy_o); end
    @(negedge clk);
    resetn = 1'b0;
    #1;
    vectors += 4;
    if (d_o !== 8'h00) begin miscompares++; $display("FAIL rst_mid_d_o: got %02h want 00", d_o); end
    if (valid_o !== 1'b0) begin miscompares++; $display("FAIL rst_mid_valid: got %b want 0", valid_o); end
    if (frame_err_o !== 1'b0) begin miscompares++; $display("FAIL rst_mid_ferr: got %b want 0", frame_err_o); end
    if (busy_o !== 1'b0) begin miscompares++; $display("FAIL rst_mid_busy: got %b want 0", busy_o); end
    rx_i = 1'b1;
    repeat (5) @(negedge clk);
    resetn = 1'b1;
    idle(3 * C);
    vectors++;
    if (got_q.size() != 0 || ferr_cyc.size() != 0) begin
      miscompares++; $display("FAIL rst_mid_pulses: got %0d want 0", got_q.size() + ferr_cyc.size());
    end
    send_frame(8'h42, 1'b1, C, 10'd0);
    idle(C);
    vectors += 2;
    if (got_q.size() != 1) begin miscompares++; $display("FAIL rst_after_count: got %0d want 1", got_q.size()); end
    if (d_o !== 8'h42) begin miscompares++; $display("FAIL rst_after_data: got %02h want 42", d_o); end
  endtask

  task automatic test_majority();
    logic [7:0] exp_b;
    logic [7:0] bv;
`ifdef UART_RX_MAJORITY_EN
    exp_b = 8'h96;
`else
    bv    = 8'h96;
    exp_b = ~bv;
`endif
    clear_log();
    send_frame(8'h96, 1'b1, C, 10'b01_1111_1110);
    idle(C);
    vectors += 2;
    if (got_q.size() != 1) begin miscompares++; $display("FAIL maj_count: got %0d want 1", got_q.size()); end
    if (d_o !== exp_b) begin miscompares++; $display("FAIL maj_data: got %02h want %02h", d_o, exp_b); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    last_fall   = 0;
    rx_i        = 1'b1;
    resetn      = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_majority();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
